// File: rtl/mcdf_prio_arbiter_if.sv
// Arbiter-side bundle: slave requests/priorities, formatter handshake, per-slave acks.
// The arbiter uses the master modport; the slave/formatter side uses the slave modport.
interface mcdf_prio_arbiter_if #(
  parameter int PRIO_W = 2
);
  logic              slv0_req_i;
  logic              slv1_req_i;
  logic              slv2_req_i;
  logic [PRIO_W-1:0] slv0_prio_i;
  logic [PRIO_W-1:0] slv1_prio_i;
  logic [PRIO_W-1:0] slv2_prio_i;
  logic              fmt_grant_i;
  logic              fmt_end_i;
  logic              fmt_req_o;
  logic [1:0]        fmt_chid_o;
  logic              a2s0_ack_o;
  logic              a2s1_ack_o;
  logic              a2s2_ack_o;
  logic              busy_o;

  modport master (
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  fmt_grant_i, fmt_end_i,
    output fmt_req_o, fmt_chid_o,
    output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o, busy_o
  );

  modport slave (
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output fmt_grant_i, fmt_end_i,
    input  fmt_req_o, fmt_chid_o,
    input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o, busy_o
  );
endinterface

// File: rtl/mcdf_prio_arbiter.sv
// Three-channel formatter arbiter: lowest priority value wins, round-robin among equals,
// then a req/grant handshake with the formatter and ownership held until end of packet.
module mcdf_prio_arbiter #(
  parameter int PRIO_W = 2,
  parameter int CH_NUM = 3
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mcdf_prio_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t              state, state_nxt;
  logic [1:0]          last_id, last_id_nxt;
  logic [1:0]          chid, chid_nxt;
  logic                fmt_req, fmt_req_nxt;
  logic                busy, busy_nxt;
  logic [CH_NUM-1:0]   ack, ack_nxt;

  logic [CH_NUM-1:0]   req;
  logic [PRIO_W-1:0]   prio [CH_NUM];
  logic                win_vld;
  logic [1:0]          win_id;
  logic [PRIO_W-1:0]   win_prio;

  assign req     = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign prio[0] = bus.slv0_prio_i;
  assign prio[1] = bus.slv1_prio_i;
  assign prio[2] = bus.slv2_prio_i;

  function automatic logic [1:0] scan_id(input logic [1:0] base, input int step);
    int s;
    s = (int'(base) + step) % CH_NUM;
    return 2'(s);
  endfunction

  // Scan from the channel after the last owner; only a strictly lower value
  // displaces an earlier find, so ties go to the first channel in scan order.
  always_comb begin
    logic [1:0] idx;
    idx      = 2'd0;
    win_vld  = 1'b0;
    win_id   = 2'd0;
    win_prio = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = scan_id(last_id, k);
      if (req[idx] && (!win_vld || prio[idx] < win_prio)) begin
        win_vld  = 1'b1;
        win_id   = idx;
        win_prio = prio[idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = REQ;
      REQ: begin
        // Withdrawal beats a simultaneous grant.
        if (!req[chid])           state_nxt = IDLE;
        else if (bus.fmt_grant_i) state_nxt = XFER;
      end
      XFER:    if (bus.fmt_end_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fmt_req_nxt = (state_nxt == REQ);
    busy_nxt    = (state_nxt != IDLE);
    chid_nxt    = chid;
    ack_nxt     = '0;
    last_id_nxt = last_id;
    if (state == IDLE && win_vld)        chid_nxt      = win_id;
    if (state == REQ && state_nxt == XFER) ack_nxt[chid] = 1'b1;
    if (state == XFER && state_nxt == IDLE) last_id_nxt  = chid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last_id <= 2'd2;
      chid    <= 2'd0;
      fmt_req <= 1'b0;
      busy    <= 1'b0;
      ack     <= '0;
    end else begin
      state   <= state_nxt;
      last_id <= last_id_nxt;
      chid    <= chid_nxt;
      fmt_req <= fmt_req_nxt;
      busy    <= busy_nxt;
      ack     <= ack_nxt;
    end
  end

  assign bus.fmt_req_o  = fmt_req;
  assign bus.fmt_chid_o = chid;
  assign bus.a2s0_ack_o = ack[0];
  assign bus.a2s1_ack_o = ack[1];
  assign bus.a2s2_ack_o = ack[2];
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_mcdf_prio_arbiter.sv
// Self-checking bench for mcdf_prio_arbiter: directed scenarios plus randomized packets
// against a transaction-level model of priority/round-robin selection.
module tb_mcdf_prio_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mdl_last = 2;

  always #5 clk = ~clk;

  mcdf_prio_arbiter_if #(.PRIO_W(2)) bus ();

  mcdf_prio_arbiter #(.PRIO_W(2), .CH_NUM(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Winner = requester minimising (priority, distance after last owner).
  function automatic logic [1:0] ref_winner(input logic [2:0] r, input logic [1:0] p0,
                                            input logic [1:0] p1, input logic [1:0] p2,
                                            input int last);
    int p [3];
    int best, best_key, key;
    p[0] = int'(p0); p[1] = int'(p1); p[2] = int'(p2);
    best = 0; best_key = 1000;
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        key = p[i] * 3 + (i - last + 5) % 3;
        if (key < best_key) begin best_key = key; best = i; end
      end
    end
    return 2'(best);
  endfunction

  function automatic logic [4:0] ctl();
    return {bus.fmt_req_o, bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o, bus.busy_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [1:0] p0, input logic [1:0] p1,
                       input logic [1:0] p2);
    {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i} = r;
    bus.slv0_prio_i = p0;
    bus.slv1_prio_i = p1;
    bus.slv2_prio_i = p2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 2'd0, 2'd0, 2'd0);
    bus.fmt_grant_i = 1'b0;
    bus.fmt_end_i   = 1'b0;
    step();
    rst = 1'b0;
    mdl_last = 2;
  endtask

  // One full packet from an IDLE arbiter: request, hold, grant/ack, transfer, end.
  task automatic run_packet(input logic [2:0] r, input logic [1:0] p0, input logic [1:0] p1,
                            input logic [1:0] p2, input int gdly, input int edly,
                            input bit drop, output logic [1:0] got);
    logic [1:0] e;
    logic [4:0] want;
    e = ref_winner(r, p0, p1, p2, mdl_last);
    drive(r, p0, p1, p2);
    step();
    got  = bus.fmt_chid_o;
    want = 5'b10001;
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {want, e}) begin
      errors++;
      $display("FAIL pkt_req: got ctl=%b chid=%0d want ctl=%b chid=%0d", ctl(), bus.fmt_chid_o, want, e);
    end
    for (int i = 0; i < gdly; i++) begin
      step();
      checks++;
      if ({ctl(), bus.fmt_chid_o} !== {want, e}) begin
        errors++;
        $display("FAIL pkt_hold: got ctl=%b chid=%0d want ctl=%b chid=%0d", ctl(), bus.fmt_chid_o, want, e);
      end
    end
    bus.fmt_grant_i = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    want = {1'b0, 3'b001 << e, 1'b1};
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {want, e}) begin
      errors++;
      $display("FAIL pkt_ack: got ctl=%b chid=%0d want ctl=%b chid=%0d", ctl(), bus.fmt_chid_o, want, e);
    end
    if (drop) begin
      r[e] = 1'b0;
      drive(r, p0, p1, p2);
    end
    want = 5'b00001;
    for (int i = 0; i < edly; i++) begin
      step();
      checks++;
      if ({ctl(), bus.fmt_chid_o} !== {want, e}) begin
        errors++;
        $display("FAIL pkt_xfer: got ctl=%b chid=%0d want ctl=%b chid=%0d", ctl(), bus.fmt_chid_o, want, e);
      end
    end
    bus.fmt_end_i = 1'b1;
    step();
    bus.fmt_end_i = 1'b0;
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL pkt_end: got ctl=%b want ctl=00000", ctl());
    end
    mdl_last = int'(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b111, 2'd0, 2'd1, 2'd2);
    bus.fmt_grant_i = 1'b1;
    bus.fmt_end_i   = 1'b1;
    step();
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs: got ctl=%b chid=%0d want all zero", ctl(), bus.fmt_chid_o);
    end
    drive(3'b000, 2'd0, 2'd0, 2'd0);
    bus.fmt_grant_i = 1'b0;
    bus.fmt_end_i   = 1'b0;
    rst = 1'b0;
    mdl_last = 2;
    step();
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_idle: got ctl=%b chid=%0d want all zero", ctl(), bus.fmt_chid_o);
    end
  endtask

  task automatic test_single();
    logic [1:0] got;
    run_packet(3'b010, 2'd0, 2'd0, 2'd0, 2, 4, 1'b1, got);
    checks++;
    if (got !== 2'd1) begin
      errors++;
      $display("FAIL single_chid: got %0d want 1", got);
    end
  endtask

  task automatic test_strict_prio();
    logic [1:0] got;
    logic [2:0] reqs [3];
    logic [1:0] exp  [3];
    reqs = '{3'b111, 3'b011, 3'b001};
    exp  = '{2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 3; k++) begin
      run_packet(reqs[k], 2'd2, 2'd1, 2'd0, 1, 2, 1'b1, got);
      checks++;
      if (got !== exp[k]) begin
        errors++;
        $display("FAIL strict_order[%0d]: got %0d want %0d", k, got, exp[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] got;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_packet(3'b111, 2'd1, 2'd1, 2'd1, k % 2, 1, 1'b0, got);
      checks++;
      if (got !== 2'(k % 3)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", k, got, k % 3);
      end
    end
    drive(3'b000, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic test_withdraw();
    do_reset();
    drive(3'b101, 2'd0, 2'd0, 2'd0);
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {5'b10001, 2'd0}) begin
      errors++;
      $display("FAIL wd_req0: got ctl=%b chid=%0d want ctl=10001 chid=0", ctl(), bus.fmt_chid_o);
    end
    bus.slv0_req_i  = 1'b0;
    bus.fmt_grant_i = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL wd_noack: got ctl=%b want 00000", ctl());
    end
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {5'b10001, 2'd2}) begin
      errors++;
      $display("FAIL wd_next2: got ctl=%b chid=%0d want ctl=10001 chid=2", ctl(), bus.fmt_chid_o);
    end
    bus.slv2_req_i = 1'b0;
    step();
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL wd_idle: got ctl=%b want 00000", ctl());
    end
    drive(3'b111, 2'd0, 2'd0, 2'd0);
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {5'b10001, 2'd0}) begin
      errors++;
      $display("FAIL wd_tie0: got ctl=%b chid=%0d want ctl=10001 chid=0", ctl(), bus.fmt_chid_o);
    end
    drive(3'b000, 2'd0, 2'd0, 2'd0);
    step();
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL wd_clear: got ctl=%b want 00000", ctl());
    end
  endtask

  task automatic test_ignored();
    logic [4:0] want [6];
    want = '{5'b00000, 5'b10001, 5'b00101, 5'b00001, 5'b00001, 5'b00000};
    bus.fmt_grant_i = 1'b1;
    bus.fmt_end_i   = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    bus.fmt_end_i   = 1'b0;
    checks++;
    if (ctl() !== want[0]) begin
      errors++;
      $display("FAIL ign_idle: got ctl=%b want %b", ctl(), want[0]);
    end
    drive(3'b010, 2'd3, 2'd3, 2'd3);
    step();
    bus.fmt_end_i = 1'b1;
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {want[1], 2'd1}) begin
      errors++;
      $display("FAIL ign_end_in_req: got ctl=%b chid=%0d want %b chid=1", ctl(), bus.fmt_chid_o, want[1]);
    end
    bus.fmt_grant_i = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    bus.fmt_end_i   = 1'b0;
    checks++;
    if (ctl() !== want[2]) begin
      errors++;
      $display("FAIL ign_ack: got ctl=%b want %b", ctl(), want[2]);
    end
    step();
    checks++;
    if (ctl() !== want[3]) begin
      errors++;
      $display("FAIL ign_end_on_ack_edge: got ctl=%b want %b", ctl(), want[3]);
    end
    bus.fmt_grant_i = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {want[4], 2'd1}) begin
      errors++;
      $display("FAIL ign_grant_in_xfer: got ctl=%b chid=%0d want %b chid=1", ctl(), bus.fmt_chid_o, want[4]);
    end
    bus.slv1_req_i = 1'b0;
    bus.fmt_end_i  = 1'b1;
    step();
    bus.fmt_end_i = 1'b0;
    mdl_last = 1;
    checks++;
    if (ctl() !== want[5]) begin
      errors++;
      $display("FAIL ign_end: got ctl=%b want %b", ctl(), want[5]);
    end
  endtask

  task automatic test_reset_xfer();
    drive(3'b010, 2'd0, 2'd0, 2'd0);
    step();
    bus.fmt_grant_i = 1'b1;
    step();
    bus.fmt_grant_i = 1'b0;
    step();
    rst = 1'b1;
    drive(3'b111, 2'd1, 2'd1, 2'd1);
    step();
    rst = 1'b0;
    mdl_last = 2;
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== 7'd0) begin
      errors++;
      $display("FAIL rstx_outs: got ctl=%b chid=%0d want all zero", ctl(), bus.fmt_chid_o);
    end
    step();
    checks++;
    if ({ctl(), bus.fmt_chid_o} !== {5'b10001, 2'd0}) begin
      errors++;
      $display("FAIL rstx_first: got ctl=%b chid=%0d want ctl=10001 chid=0", ctl(), bus.fmt_chid_o);
    end
    drive(3'b000, 2'd0, 2'd0, 2'd0);
    step();
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL rstx_clear: got ctl=%b want 00000", ctl());
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [1:0] p0, p1, p2, e, got;
    for (int n = 0; n < 40; n++) begin
      r  = 3'($urandom_range(1, 7));
      p0 = 2'($urandom); p1 = 2'($urandom); p2 = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        e = ref_winner(r, p0, p1, p2, mdl_last);
        drive(r, p0, p1, p2);
        step();
        checks++;
        if ({ctl(), bus.fmt_chid_o} !== {5'b10001, e}) begin
          errors++;
          $display("FAIL rnd_req[%0d]: got ctl=%b chid=%0d want ctl=10001 chid=%0d", n, ctl(), bus.fmt_chid_o, e);
        end
        // Priorities change mid-REQ; they must not matter.
        drive(r, 2'($urandom), 2'($urandom), 2'($urandom));
        r[e] = 1'b0;
        {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i} = r;
        bus.fmt_grant_i = 1'($urandom_range(0, 1));
        step();
        bus.fmt_grant_i = 1'b0;
        checks++;
        if (ctl() !== 5'b00000) begin
          errors++;
          $display("FAIL rnd_withdraw[%0d]: got ctl=%b want 00000", n, ctl());
        end
      end else begin
        run_packet(r, p0, p1, p2, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), got);
      end
    end
    drive(3'b000, 2'd0, 2'd0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_strict_prio();
    test_round_robin();
    test_withdraw();
    test_ignored();
    test_reset_xfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
